// File: rtl/eviction_write_buffer.sv
// Line-granular write buffer between the cache arbiter and physical memory.
// Absorbs line write-backs, forwards read hits, and drains FIFO-ordered entries while idle.
module eviction_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_READ_MEM,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_valid [DEPTH];
    logic [11:0]        r_tag   [DEPTH];
    logic [127:0]       r_data  [DEPTH];
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [127:0]       r_rdata;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_full;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);

    // Coalescing keeps tags unique among valid entries, so at most one hit.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == mem_address[15:4])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_read) begin
                    w_next = w_hit ? S_RESP : S_READ_MEM;
                end else if (mem_write) begin
                    w_next = (w_hit || !w_full) ? S_RESP : S_DRAIN;
                end else if (!empty) begin
                    w_next = S_DRAIN;
                end
            end
            S_RESP:     w_next = S_IDLE;
            S_READ_MEM: if (pmem_resp) w_next = S_IDLE;
            S_DRAIN:    if (pmem_resp) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            S_RESP: begin
                mem_resp  = 1'b1;
                mem_rdata = r_rdata;
            end
            S_READ_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = mem_address;
                if (pmem_resp) begin
                    mem_resp  = 1'b1;
                    mem_rdata = pmem_rdata;
                end
            end
            S_DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_head], 4'b0000};
                pmem_wdata   = r_data[r_head];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_read) begin
                        if (w_hit) begin
                            r_rdata <= r_data[w_hit_idx];
                        end
                    end else if (mem_write) begin
                        if (w_hit) begin
                            r_data[w_hit_idx] <= mem_wdata;
                            r_rdata           <= '0;
                        end else if (!w_full) begin
                            r_valid[r_tail] <= 1'b1;
                            r_tag[r_tail]   <= mem_address[15:4];
                            r_data[r_tail]  <= mem_wdata;
                            r_tail          <= r_tail + IDX_W'(1);
                            r_count         <= r_count + CNT_W'(1);
                            r_rdata         <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) begin
                        r_valid[r_head] <= 1'b0;
                        r_head          <= r_head + IDX_W'(1);
                        r_count         <= r_count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer: write/drain, forwarding, coalescing,
// full-buffer stall, read priority and asynchronous reset during a drain.
module tb_eviction_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         empty;

    int n_cmp = 0;
    int n_err = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    eviction_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pmem_read) n_rd++;
        if (pmem_write && pmem_resp) n_wr++;
    end

    localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DC = 128'hCCCC_0000_CCCC_0000_CCCC_0000_CCCC_0000;
    localparam logic [127:0] DD = 128'hDDDD_5555_DDDD_6666_DDDD_7777_DDDD_8888;
    localparam logic [127:0] DE = 128'hEEEE_9999_EEEE_AAAA_EEEE_BBBB_EEEE_CCCC;
    localparam logic [127:0] DF = 128'hFFFF_0123_FFFF_4567_FFFF_89AB_FFFF_CDEF;
    localparam logic [127:0] D7 = 128'h7777_7777_7777_7777_7777_7777_7777_7777;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL rst_mem_resp: got %b want 0", mem_resp); end
        n_cmp++; if (pmem_read !== 1'b0) begin n_err++; $display("FAIL rst_pmem_read: got %b want 0", pmem_read); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_err++; $display("FAIL rst_pmem_write: got %b want 0", pmem_write); end
        n_cmp++; if (pmem_address !== 16'h0) begin n_err++; $display("FAIL rst_pmem_address: got %h want 0", pmem_address); end
        n_cmp++; if (pmem_wdata !== 128'h0) begin n_err++; $display("FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
        n_cmp++; if (mem_rdata !== 128'h0) begin n_err++; $display("FAIL rst_mem_rdata: got %h want 0", mem_rdata); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
        step();
        step();
        reset = 1'b0;
        mid();
        n_cmp++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin n_err++; $display("FAIL rst_idle: got rd=%b wr=%b want 0 0", pmem_read, pmem_write); end
    endtask

    task automatic test_single_write();
        mem_write = 1'b1; mem_address = 16'h1230; mem_wdata = DA;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL sw_resp: got %b want 1", mem_resp); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL sw_not_empty: got %b want 0", empty); end
        step();
        mem_write = 1'b0; mem_address = 16'h0;
        mid();
        n_cmp++; if (mem_resp !== 1'b0 || pmem_write !== 1'b0) begin n_err++; $display("FAIL sw_idle: got resp=%b wr=%b want 0 0", mem_resp, pmem_write); end
        step();
        pmem_resp = 1'b1;
        mid();
        n_cmp++; if (pmem_write !== 1'b1) begin n_err++; $display("FAIL sw_drain_wr: got %b want 1", pmem_write); end
        n_cmp++; if (pmem_address !== 16'h1230) begin n_err++; $display("FAIL sw_drain_addr: got %h want 1230", pmem_address); end
        n_cmp++; if (pmem_wdata !== DA) begin n_err++; $display("FAIL sw_drain_data: got %h want %h", pmem_wdata, DA); end
        step();
        pmem_resp = 1'b0;
        mid();
        n_cmp++; if (empty !== 1'b1 || pmem_write !== 1'b0) begin n_err++; $display("FAIL sw_done: got empty=%b wr=%b want 1 0", empty, pmem_write); end
    endtask

    task automatic test_forward();
        int n0;
        n0 = n_rd;
        mem_write = 1'b1; mem_address = 16'h2000; mem_wdata = DB;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL fw_wr_resp: got %b want 1", mem_resp); end
        step();
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h2000;
        mid();
        n_cmp++; if (mem_rdata !== 128'h0) begin n_err++; $display("FAIL fw_idle_rdata: got %h want 0", mem_rdata); end
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL fw_rd_resp: got %b want 1", mem_resp); end
        n_cmp++; if (mem_rdata !== DB) begin n_err++; $display("FAIL fw_rd_data: got %h want %h", mem_rdata, DB); end
        step();
        mem_read = 1'b0; mem_address = 16'h0;
        step();
        pmem_resp = 1'b1;
        mid();
        n_cmp++; if (pmem_write !== 1'b1 || pmem_address !== 16'h2000 || pmem_wdata !== DB) begin
            n_err++; $display("FAIL fw_drain: got wr=%b addr=%h data=%h want 1 2000 %h", pmem_write, pmem_address, pmem_wdata, DB); end
        step();
        pmem_resp = 1'b0;
        mid();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fw_empty: got %b want 1", empty); end
        n_cmp++; if (n_rd !== n0) begin n_err++; $display("FAIL fw_no_pmem_read: got %0d cycles want %0d", n_rd, n0); end
    endtask

    task automatic test_coalesce();
        int n0;
        n0 = n_wr;
        mem_write = 1'b1; mem_address = 16'h3000; mem_wdata = DC;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL co_resp1: got %b want 1", mem_resp); end
        step();
        mem_address = 16'h3008; mem_wdata = DD;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL co_resp2: got %b want 1", mem_resp); end
        step();
        mem_write = 1'b0; mem_address = 16'h0;
        step();
        pmem_resp = 1'b1;
        mid();
        n_cmp++; if (pmem_address !== 16'h3000) begin n_err++; $display("FAIL co_drain_addr: got %h want 3000", pmem_address); end
        n_cmp++; if (pmem_wdata !== DD) begin n_err++; $display("FAIL co_drain_data: got %h want %h", pmem_wdata, DD); end
        step();
        pmem_resp = 1'b0;
        mid();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL co_empty: got %b want 1", empty); end
        step();
        step();
        mid();
        n_cmp++; if (pmem_write !== 1'b0) begin n_err++; $display("FAIL co_no_more: got %b want 0", pmem_write); end
        n_cmp++; if (n_wr !== n0 + 1) begin n_err++; $display("FAIL co_one_txn: got %0d want %0d", n_wr, n0 + 1); end
    endtask

    task automatic test_full();
        logic [15:0]  a;
        logic [127:0] d;
        for (int i = 0; i < 4; i++) begin
            mem_write = 1'b1; mem_address = 16'(i + 1) << 12; mem_wdata = {4{32'hD000_0000 + 32'(i)}};
            step();
            mid();
            n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL full_resp%0d: got %b want 1", i, mem_resp); end
            step();
        end
        mem_address = 16'h5000; mem_wdata = {4{32'hD000_0004}};
        step();
        pmem_resp = 1'b1;
        mid();
        n_cmp++; if (pmem_write !== 1'b1 || pmem_address !== 16'h1000) begin n_err++; $display("FAIL full_first_drain: got wr=%b addr=%h want 1 1000", pmem_write, pmem_address); end
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL full_no_early_resp: got %b want 0", mem_resp); end
        step();
        pmem_resp = 1'b0;
        mid();
        n_cmp++; if (mem_resp !== 1'b0 || pmem_write !== 1'b0) begin n_err++; $display("FAIL full_idle_gap: got resp=%b wr=%b want 0 0", mem_resp, pmem_write); end
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL full_5th_resp: got %b want 1", mem_resp); end
        step();
        mem_write = 1'b0; mem_address = 16'h0;
        for (int j = 1; j < 5; j++) begin
            a = 16'(j + 1) << 12;
            d = {4{32'hD000_0000 + 32'(j)}};
            step();
            pmem_resp = 1'b1;
            mid();
            n_cmp++; if (pmem_write !== 1'b1 || pmem_address !== a || pmem_wdata !== d) begin
                n_err++; $display("FAIL full_order%0d: got wr=%b addr=%h data=%h want 1 %h %h", j, pmem_write, pmem_address, pmem_wdata, a, d); end
            step();
            pmem_resp = 1'b0;
        end
        mid();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_empty: got %b want 1", empty); end
    endtask

    task automatic test_read_priority();
        int n0;
        n0 = n_rd;
        mem_write = 1'b1; mem_address = 16'h5000; mem_wdata = DF;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL rp_wr_resp: got %b want 1", mem_resp); end
        step();
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h6000;
        step();
        mid();
        n_cmp++; if (pmem_read !== 1'b1 || pmem_address !== 16'h6000 || pmem_write !== 1'b0) begin
            n_err++; $display("FAIL rp_miss: got rd=%b addr=%h wr=%b want 1 6000 0", pmem_read, pmem_address, pmem_write); end
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL rp_wait1: got %b want 0", mem_resp); end
        step();
        mid();
        n_cmp++; if (pmem_read !== 1'b1 || mem_resp !== 1'b0) begin n_err++; $display("FAIL rp_wait2: got rd=%b resp=%b want 1 0", pmem_read, mem_resp); end
        step();
        pmem_resp = 1'b1; pmem_rdata = DE;
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL rp_resp: got %b want 1", mem_resp); end
        n_cmp++; if (mem_rdata !== DE) begin n_err++; $display("FAIL rp_rdata: got %h want %h", mem_rdata, DE); end
        step();
        pmem_resp = 1'b0; pmem_rdata = '0; mem_read = 1'b0; mem_address = 16'h0;
        mid();
        n_cmp++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin n_err++; $display("FAIL rp_release: got rd=%b resp=%b want 0 0", pmem_read, mem_resp); end
        step();
        pmem_resp = 1'b1;
        mid();
        n_cmp++; if (pmem_write !== 1'b1 || pmem_address !== 16'h5000 || pmem_wdata !== DF) begin
            n_err++; $display("FAIL rp_drain: got wr=%b addr=%h data=%h want 1 5000 %h", pmem_write, pmem_address, pmem_wdata, DF); end
        step();
        pmem_resp = 1'b0;
        mid();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rp_empty: got %b want 1", empty); end
        n_cmp++; if (n_rd !== n0 + 3) begin n_err++; $display("FAIL rp_read_cycles: got %0d want %0d", n_rd - n0, 3); end
    endtask

    task automatic test_reset_mid_drain();
        mem_write = 1'b1; mem_address = 16'h7000; mem_wdata = D7;
        step();
        mid();
        n_cmp++; if (mem_resp !== 1'b1) begin n_err++; $display("FAIL rd_wr_resp: got %b want 1", mem_resp); end
        step();
        mem_write = 1'b0; mem_address = 16'h0;
        step();
        mid();
        n_cmp++; if (pmem_write !== 1'b1) begin n_err++; $display("FAIL rd_in_drain: got %b want 1", pmem_write); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (pmem_write !== 1'b0) begin n_err++; $display("FAIL rd_async_drop: got %b want 0", pmem_write); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rd_async_empty: got %b want 1", empty); end
        n_cmp++; if (pmem_address !== 16'h0) begin n_err++; $display("FAIL rd_async_addr: got %h want 0", pmem_address); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            n_cmp++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || empty !== 1'b1) begin
                n_err++; $display("FAIL rd_quiet%0d: got wr=%b rd=%b empty=%b want 0 0 1", k, pmem_write, pmem_read, empty); end
            step();
        end
    endtask

    initial begin
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        test_reset();
        test_single_write();
        test_forward();
        test_coalesce();
        test_full();
        test_read_priority();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
